acum_sched: RTL and testbench
=============================

// Module: acum_sched
// PURPOSE
//  Round-robin scheduler sharing one accumulator datapath among N_REQ requesters.
//  Per burst: grants one requester, clears accumulator, forwards BURST_LEN accepted samples,
//  waits out accumulator latency, returns result/overflow tagged with requester id.
//  Sits between sample producers and the accumulator; owns its clear and enable sequencing.
// PARAMETERS
//  NB_INPUT   3  sample width is NB_INPUT+1; result width is NB_INPUT+4
//  N_REQ      2  number of requesters (>=2)
//  BURST_LEN  8  accepted samples per burst (>=1)
//  ACC_LAT    2  cycles from s_acc_en to e_acc_result reflecting that sample
// PORTS
//  e_clk         in   1                  clock, rising edge
//  e_reset       in   1                  synchronous reset, active-low
//  e_req         in   N_REQ              request per requester, level
//  e_valid       in   N_REQ              sample valid per requester
//  e_data        in   N_REQ*(NB_INPUT+1) packed samples; requester i at [i*(NB_INPUT+1) +: NB_INPUT+1]
//  s_ready       out  N_REQ              sample accepted when s_ready[i] & e_valid[i]
//  s_grant       out  N_REQ              one-hot current owner; 0 when idle
//  s_acc_clr     out  1                  accumulator clear, 1-cycle pulse
//  s_acc_en      out  1                  accumulator add enable
//  s_acc_sum     out  NB_INPUT+1         operand to accumulator
//  e_acc_result  in   NB_INPUT+4         accumulator output
//  e_acc_ovf     in   1                  accumulator overflow flag
//  s_done        out  1                  burst complete, 1-cycle pulse
//  s_done_id     out  $clog2(N_REQ)      owner of completed burst
//  s_result      out  NB_INPUT+4         captured result, held until next s_done
//  s_overflow    out  1                  overflow seen during burst, held with s_result
//  s_busy        out  1                  high in any state except IDLE
// BEHAVIOUR
//  - All outputs registered. e_reset==0 at clock edge: state IDLE, rr pointer 0, every output 0.
//  - Reset mid-burst: burst discarded, no s_done, no s_acc_clr; next burst's CLEAR re-inits datapath.
//  - FSM: IDLE -> CLEAR -> ACCUM -> DRAIN -> DONE -> IDLE.
//  - IDLE: if any e_req, grant first requester at/after rr pointer (wrap N_REQ-1 -> 0); next CLEAR.
//  - CLEAR: 1 cycle, s_acc_clr=1, clear sample counter and sticky overflow; next ACCUM.
//  - ACCUM: s_ready = s_grant. On handshake: s_acc_sum<=grantee data, s_acc_en<=1 next cycle,
//    count++. Non-accepted cycles: s_acc_en<=0, s_acc_sum holds. BURST_LEN-th acceptance -> DRAIN.
//  - Abort: grantee e_req low in ACCUM without handshake that cycle -> IDLE, s_grant<=0,
//    no s_done, pointer <= grantee+1. Drop coinciding with final acceptance: burst completes.
//  - DRAIN: exactly ACC_LAT+1 cycles, s_ready=0. Sticky overflow ORs e_acc_ovf from CLEAR exit to DRAIN end.
//  - DONE: s_done=1, s_result<=e_acc_result, s_overflow<=sticky, s_done_id<=grantee index;
//    pointer <= grantee+1 mod N_REQ; next IDLE (one idle cycle between bursts).
//  - Grant fixed from CLEAR through DONE; other e_req/e_valid ignored until IDLE.
//  - Latency, continuous valid: s_done high BURST_LEN+ACC_LAT+5 cycles after e_req first sampled in IDLE.
//  - Width: no arithmetic on data here; result width NB_INPUT+4 must match accumulator.
// STRUCTURE
//  - acum_pkg: state encoding localparams, sample/result width constants, id width.
//  - Sub-module rr_arbiter (N_REQ, req, pointer -> one-hot grant + index), combinational.
//  - acum_sched: FSM, burst/drain counters, sticky overflow, output registers.
// TESTING  (NB_INPUT=3, N_REQ=2, BURST_LEN=4, ACC_LAT=2, bench accumulator model)
//  1 Reset: e_reset=0 for 2 cycles mid-ACCUM -> all outputs 0, no s_done; then req1 alone -> s_grant=2'b10.
//  2 req0, data 1,2,3,4 continuous -> one s_acc_clr, 4 s_acc_en, s_done 11 cycles after req,
//    s_done_id=0, s_result=10, s_overflow=0.
//  3 req0,req1 held high, 3 bursts -> s_done_id sequence 0,1,0; grants never overlap.
//  4 req0 e_valid pattern 1,0,1,0,1,0,1 data 5 each -> exactly 4 s_acc_en, s_result=20.
//  5 Model forces e_acc_ovf=1 one cycle mid-burst -> s_overflow=1; next clean burst -> s_overflow=0.
//  6 req0 drops after 2 samples, req1 pending -> no s_done for 0, IDLE, next grant 2'b10, completes id=1.

Source files
------------

// File: rtl/acum_sched_pkg.sv
// acum_sched_pkg: state encoding and width helpers shared by the accumulator scheduler
package acum_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN, S_DONE} state_t;
  function automatic int sample_w(int nb);
    return nb + 1;
  endfunction
  function automatic int result_w(int nb);
    return nb + 4;
  endfunction
  function automatic int id_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/acum_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
  import acum_sched_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]        req,
  input  logic [id_w(N)-1:0]  ptr,
  output logic [N-1:0]        grant,
  output logic [id_w(N)-1:0]  idx,
  output logic                any
);
  localparam int IW = id_w(N);
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    // walk offsets from farthest to nearest so the nearest request wins
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        grant = '0;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/acum_sched.sv
// acum_sched: round-robin scheduler sharing one accumulator among N_REQ requesters
module acum_sched
  import acum_sched_pkg::*;
#(
  parameter int NB_INPUT  = 3,
  parameter int N_REQ     = 2,
  parameter int BURST_LEN = 8,
  parameter int ACC_LAT   = 2
) (
  input  logic                                  e_clk,
  input  logic                                  e_reset,
  input  logic [N_REQ-1:0]                      e_req,
  input  logic [N_REQ-1:0]                      e_valid,
  input  logic [N_REQ*sample_w(NB_INPUT)-1:0]   e_data,
  output logic [N_REQ-1:0]                      s_ready,
  output logic [N_REQ-1:0]                      s_grant,
  output logic                                  s_acc_clr,
  output logic                                  s_acc_en,
  output logic [sample_w(NB_INPUT)-1:0]         s_acc_sum,
  input  logic [result_w(NB_INPUT)-1:0]         e_acc_result,
  input  logic                                  e_acc_ovf,
  output logic                                  s_done,
  output logic [id_w(N_REQ)-1:0]                s_done_id,
  output logic [result_w(NB_INPUT)-1:0]         s_result,
  output logic                                  s_overflow,
  output logic                                  s_busy
);
  localparam int SW = sample_w(NB_INPUT);
  localparam int RW = result_w(NB_INPUT);
  localparam int IW = id_w(N_REQ);
  localparam int CW = $clog2((BURST_LEN > ACC_LAT ? BURST_LEN : ACC_LAT + 1) + 1);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gidx_q, gidx_d, id_q, id_d, arb_idx, nxt_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] ready_q, ready_d, grant_q, grant_d, arb_grant;
  logic [SW-1:0] sum_q, sum_d, data_sel;
  logic [RW-1:0] result_q, result_d;
  logic sticky_q, sticky_d, clr_q, clr_d, en_q, en_d, done_q, done_d;
  logic ovf_q, ovf_d, busy_q, busy_d, arb_any, hs;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (e_req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );
  assign hs       = |(ready_q & e_valid);
  assign data_sel = e_data[gidx_q*SW +: SW];
  assign nxt_ptr  = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    ready_d  = '0;
    clr_d    = 1'b0;
    en_d     = 1'b0;
    sum_d    = sum_q;
    done_d   = 1'b0;
    id_d     = id_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: if (arb_any) begin
        state_d = S_CLEAR;
        grant_d = arb_grant;
        gidx_d  = arb_idx;
      end
      S_CLEAR: begin
        state_d  = S_ACCUM;
        clr_d    = 1'b1;
        cnt_d    = '0;
        sticky_d = 1'b0;
      end
      S_ACCUM: begin
        sticky_d = sticky_q | e_acc_ovf;
        en_d     = hs;
        sum_d    = hs ? data_sel : sum_q;
        cnt_d    = hs ? cnt_q + CW'(1) : cnt_q;
        // an acceptance on the final sample outranks a dropped request
        if (hs && cnt_q == CW'(BURST_LEN - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else if (!hs && !e_req[gidx_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          ptr_d   = nxt_ptr;
        end else ready_d = grant_q;
      end
      S_DRAIN: begin
        sticky_d = sticky_q | e_acc_ovf;
        state_d  = (cnt_q == CW'(ACC_LAT)) ? S_DONE : S_DRAIN;
        cnt_d    = cnt_q + CW'(1);
      end
      S_DONE: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        result_d = e_acc_result;
        ovf_d    = sticky_q;
        id_d     = gidx_q;
        ptr_d    = nxt_ptr;
        grant_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge e_clk) begin
    if (!e_reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      ready_q  <= '0;
      clr_q    <= 1'b0;
      en_q     <= 1'b0;
      sum_q    <= '0;
      done_q   <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      ready_q  <= ready_d;
      clr_q    <= clr_d;
      en_q     <= en_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
      id_q     <= id_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end
  assign s_ready    = ready_q;
  assign s_grant    = grant_q;
  assign s_acc_clr  = clr_q;
  assign s_acc_en   = en_q;
  assign s_acc_sum  = sum_q;
  assign s_done     = done_q;
  assign s_done_id  = id_q;
  assign s_result   = result_q;
  assign s_overflow = ovf_q;
  assign s_busy     = busy_q;
endmodule

// File: tb/tb_acum_sched.sv
// tb_acum_sched: directed bursts with a queued scoreboard and a two-cycle accumulator model
module tb_acum_sched;
  localparam int NB = 3, N = 2, BL = 4, AL = 2, SW = NB + 1, RW = NB + 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [N-1:0] req = '0, valid = '0, ready, grant;
  logic [N*SW-1:0] data = '0;
  logic clr, en, done, ovf, busy, acc_ovf = 1'b0;
  logic [SW-1:0] sum;
  logic [RW-1:0] acc_res, result;
  logic [0:0] done_id;
  typedef struct packed {logic [0:0] id; logic [RW-1:0] res; logic ovf;} exp_t;
  exp_t exp_q[$];
  logic [SW-1:0] samp0[$], samp1[$];
  int checks = 0, errors = 0, en_cnt = 0, clr_cnt = 0;
  bit toggle = 0, phase = 0;
  logic [RW-1:0] acc_q = '0, res_q = '0;

  acum_sched #(.NB_INPUT(NB), .N_REQ(N), .BURST_LEN(BL), .ACC_LAT(AL)) dut (
    .e_clk(clk), .e_reset(rst_n), .e_req(req), .e_valid(valid), .e_data(data),
    .s_ready(ready), .s_grant(grant), .s_acc_clr(clr), .s_acc_en(en), .s_acc_sum(sum),
    .e_acc_result(acc_res), .e_acc_ovf(acc_ovf), .s_done(done), .s_done_id(done_id),
    .s_result(result), .s_overflow(ovf), .s_busy(busy)
  );

  // accumulator: add lands one edge after s_acc_en, result visible one edge later
  always @(posedge clk) begin
    acc_q <= clr ? '0 : en ? acc_q + RW'(sum) : acc_q;
    res_q <= acc_q;
  end
  assign acc_res = res_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_src();
    valid[0] = samp0.size() > 0 && (!toggle || phase);
    valid[1] = samp1.size() > 0 && (!toggle || phase);
    data[SW-1:0]    = samp0.size() > 0 ? samp0[0] : '0;
    data[2*SW-1:SW] = samp1.size() > 0 ? samp1[0] : '0;
  endtask

  task automatic push(input int who, input int n, input logic [SW-1:0] v);
    for (int i = 0; i < n; i++) if (who == 0) samp0.push_back(v); else samp1.push_back(v);
    drive_src();
  endtask

  task automatic expect_done(input logic [0:0] id, input logic [RW-1:0] res, input logic o);
    exp_q.push_back('{id: id, res: res, ovf: o});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    do begin
      tick(1);
      c++;
    end while (!done && c < budget);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // producer: pops a sample whenever the pre-edge handshake fired
  initial begin
    logic [N-1:0] hs;
    drive_src();
    forever begin
      @(negedge clk);
      hs = ready & valid;
      @(posedge clk);
      #1;
      if (hs[0] && samp0.size() > 0) void'(samp0.pop_front());
      if (hs[1] && samp1.size() > 0) void'(samp1.pop_front());
      phase = ~phase;
      drive_src();
    end
  end

  // monitor: structural checks every cycle, scoreboard pop on each s_done
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("grant_onehot", {31'd0, $onehot0(grant) && (ready & ~grant) == '0}, 32'd1);
      if (clr) begin
        en_cnt = 0;
        clr_cnt++;
      end
      if (en) en_cnt++;
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", {31'd0, done_id}, 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("done_id", {31'd0, done_id}, {31'd0, e.id});
          chk("result", {25'd0, result}, {25'd0, e.res});
          chk("overflow", {31'd0, ovf}, {31'd0, e.ovf});
          chk("acc_en_count", en_cnt, BL);
        end
      end
    end
  end

  initial begin
    int lat, c;
    tick(2);
    chk("reset_outputs", {11'd0, ready, grant, clr, en, sum, done, done_id, result, ovf, busy}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    // reset in the middle of a burst discards it
    push(0, 4, 4'd7);
    req = 2'b01;
    tick(4);
    rst_n = 1'b0;
    tick(2);
    chk("midburst_reset", {11'd0, ready, grant, clr, en, sum, done, done_id, result, ovf, busy}, 32'd0);
    req = '0;
    samp0.delete();
    drive_src();
    rst_n = 1'b1;
    tick(1);
    push(1, 4, 4'd1);
    expect_done(1'b1, 7'd4, 1'b0);
    req = 2'b10;
    tick(1);
    chk("grant_req1", {30'd0, grant}, 32'd2);
    wait_done(40);
    req = '0;
    tick(2);
    // two requesters held: owners alternate 0,1,0
    push(0, 4, 4'd1);
    push(0, 4, 4'd2);
    push(1, 4, 4'd3);
    expect_done(1'b0, 7'd4, 1'b0);
    expect_done(1'b1, 7'd12, 1'b0);
    expect_done(1'b0, 7'd8, 1'b0);
    req = 2'b11;
    wait_done(40);
    wait_done(40);
    req = 2'b01;
    wait_done(40);
    req = '0;
    tick(2);
    // latency and single clear for a continuous burst of 1,2,3,4
    push(0, 1, 4'd1);
    push(0, 1, 4'd2);
    push(0, 1, 4'd3);
    push(0, 1, 4'd4);
    expect_done(1'b0, 7'd10, 1'b0);
    clr_cnt = 0;
    req = 2'b01;
    lat = 0;
    while (!done && lat < 40) begin
      tick(1);
      lat++;
    end
    chk("latency", lat, BL + AL + 5);
    chk("clear_count", clr_cnt, 1);
    req = '0;
    tick(2);
    // alternating valid
    toggle = 1;
    push(0, 4, 4'd5);
    expect_done(1'b0, 7'd20, 1'b0);
    req = 2'b01;
    wait_done(60);
    req = '0;
    toggle = 0;
    tick(2);
    // overflow pulse then a clean burst
    push(0, 4, 4'd2);
    expect_done(1'b0, 7'd8, 1'b1);
    req = 2'b01;
    tick(6);
    acc_ovf = 1'b1;
    tick(1);
    acc_ovf = 1'b0;
    wait_done(40);
    req = '0;
    tick(2);
    push(0, 4, 4'd3);
    expect_done(1'b0, 7'd12, 1'b0);
    req = 2'b01;
    wait_done(40);
    req = '0;
    tick(2);
    // requester 0 drops mid-burst; pending requester 1 takes over
    push(0, 2, 4'd6);
    push(1, 1, 4'd1);
    push(1, 1, 4'd2);
    push(1, 1, 4'd3);
    push(1, 1, 4'd4);
    expect_done(1'b1, 7'd10, 1'b0);
    req = 2'b01;
    tick(1);
    req = 2'b11;
    c = 0;
    while (samp0.size() > 0 && c < 40) begin
      tick(1);
      c++;
    end
    req = 2'b10;
    c = 0;
    while (grant != 2'b10 && c < 10) begin
      tick(1);
      c++;
    end
    chk("regrant_req1", {30'd0, grant}, 32'd2);
    wait_done(40);
    req = '0;
    tick(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
